// File: rtl/pcq_pm_pkg.sv
// Shared definitions for the pcq power-management thold sequencer:
// state encodings, counter width and wait-length limits.
package pcq_pm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CYC_MIN = 1;
  localparam int unsigned CYC_MAX = 31;

  localparam logic [STATE_W-1:0] RUN     = 3'b000;
  localparam logic [STATE_W-1:0] QUIESCE = 3'b001;
  localparam logic [STATE_W-1:0] RAISE   = 3'b010;
  localparam logic [STATE_W-1:0] SLEEP   = 3'b011;
  localparam logic [STATE_W-1:0] LOWER   = 3'b100;

  // Counter load value for an N-cycle wait; N is clamped into the legal range.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
    int unsigned c;
    if (cyc < CYC_MIN) c = CYC_MIN;
    else if (cyc > CYC_MAX) c = CYC_MAX;
    else c = cyc;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/pcq_pm_dcnt.sv
// Loadable saturating down-counter used for the quiesce and thold waits.
module pcq_pm_dcnt
  import pcq_pm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             hold,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Hold wins over load so a checkstop freezes the wait exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!hold) begin
      if (load) count <= load_val;
      else if (dec && (count != '0)) count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pcq_pm_thold_seq.sv
// Power-management thold sequencer: quiesce, raise tholds, sleep, lower tholds.
// Drives the clock-control block's pm raise-thold and ccflush-disable inputs.
module pcq_pm_thold_seq
  import pcq_pm_pkg::*;
#(
  parameter int unsigned THREADS     = 2,
  parameter int unsigned QUIESCE_CYC = 8,
  parameter int unsigned THOLD_CYC   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [THREADS-1:0] thread_pm_req,
  input  logic               pm_wake,
  input  logic               pm_quiesced,
  input  logic               cfg_pm_enable,
  input  logic               cfg_ccflush_dis,
  input  logic               rg_ck_fast_xstop,
  output logic               ct_ck_pm_raise_tholds,
  output logic               ct_ck_pm_ccflush_disable,
  output logic               pm_sleep_ack,
  output logic [2:0]         pm_state
);

  localparam logic [CNT_W-1:0] Q_LOAD = cyc_load(QUIESCE_CYC);
  localparam logic [CNT_W-1:0] T_LOAD = cyc_load(THOLD_CYC);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               sleep_go;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;
  logic               raise_nxt;

  assign sleep_go  = cfg_pm_enable & (&thread_pm_req) & ~pm_wake;
  assign raise_nxt = (state_nxt == RAISE) | (state_nxt == SLEEP);

  pcq_pm_dcnt u_dcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (1'b1),
    .hold     (rg_ck_fast_xstop),
    .zero_c   (cnt_zero)
  );

  // State register; a fast checkstop freezes sequencing in place.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else if (!rg_ck_fast_xstop) state <= state_nxt;
  end

  // Next-state and counter-load decode; RAISE and LOWER run to completion.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      RUN: begin
        if (sleep_go) begin
          state_nxt = QUIESCE;
          cnt_load  = 1'b1;
          cnt_val   = Q_LOAD;
        end
      end
      QUIESCE: begin
        if (!sleep_go) begin
          state_nxt = RUN;
        end else if (!pm_quiesced) begin
          cnt_load = 1'b1;
          cnt_val  = Q_LOAD;
        end else if (cnt_zero) begin
          state_nxt = RAISE;
          cnt_load  = 1'b1;
          cnt_val   = T_LOAD;
        end
      end
      RAISE: begin
        if (cnt_zero) state_nxt = SLEEP;
      end
      SLEEP: begin
        if (!sleep_go) begin
          state_nxt = LOWER;
          cnt_load  = 1'b1;
          cnt_val   = T_LOAD;
        end
      end
      LOWER: begin
        if (cnt_zero) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct_ck_pm_raise_tholds    <= 1'b0;
      ct_ck_pm_ccflush_disable <= 1'b0;
      pm_sleep_ack             <= 1'b0;
      pm_state                 <= RUN;
    end else if (!rg_ck_fast_xstop) begin
      ct_ck_pm_raise_tholds    <= raise_nxt;
      ct_ck_pm_ccflush_disable <= cfg_ccflush_dis & raise_nxt;
      pm_sleep_ack             <= (state_nxt == SLEEP);
      pm_state                 <= state_nxt;
    end
  end

endmodule

// File: tb/tb_pcq_pm_thold_seq.sv
// Self-checking bench for pcq_pm_thold_seq: phase-timing model plus directed cycle checks.
module tb_pcq_pm_thold_seq;

  localparam int QC = 8;
  localparam int TC = 16;

  logic       clk;
  logic       rst;
  logic [1:0] thread_pm_req;
  logic       pm_wake;
  logic       pm_quiesced;
  logic       cfg_pm_enable;
  logic       cfg_ccflush_dis;
  logic       rg_ck_fast_xstop;
  logic       ct_ck_pm_raise_tholds;
  logic       ct_ck_pm_ccflush_disable;
  logic       pm_sleep_ack;
  logic [2:0] pm_state;

  int checks = 0;
  int errors = 0;

  pcq_pm_thold_seq #(
    .THREADS     (2),
    .QUIESCE_CYC (QC),
    .THOLD_CYC   (TC)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .thread_pm_req            (thread_pm_req),
    .pm_wake                  (pm_wake),
    .pm_quiesced              (pm_quiesced),
    .cfg_pm_enable            (cfg_pm_enable),
    .cfg_ccflush_dis          (cfg_ccflush_dis),
    .rg_ck_fast_xstop         (rg_ck_fast_xstop),
    .ct_ck_pm_raise_tholds    (ct_ck_pm_raise_tholds),
    .ct_ck_pm_ccflush_disable (ct_ck_pm_ccflush_disable),
    .pm_sleep_ack             (pm_sleep_ack),
    .pm_state                 (pm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 run, 1 quiesce, 2 raise, 3 sleep, 4 lower; m_el = cycles completed in phase window.
  int   m_mode = 0;
  int   m_el   = 0;
  logic m_ccf  = 1'b0;
  bit   armed  = 1'b0;
  int   n_mode;
  int   n_el;
  bit   go;

  always_comb begin
    go     = cfg_pm_enable && (thread_pm_req == 2'b11) && !pm_wake;
    n_mode = m_mode;
    n_el   = m_el;
    case (m_mode)
      0: if (go) begin n_mode = 1; n_el = 0; end
      1: begin
        if (!go) begin n_mode = 0; n_el = 0; end
        else if (!pm_quiesced) n_el = 0;
        else if (m_el + 1 >= QC) begin n_mode = 2; n_el = 0; end
        else n_el = m_el + 1;
      end
      2: if (m_el + 1 >= TC) begin n_mode = 3; n_el = 0; end else n_el = m_el + 1;
      3: if (!go) begin n_mode = 4; n_el = 0; end
      4: if (m_el + 1 >= TC) begin n_mode = 0; n_el = 0; end else n_el = m_el + 1;
      default: begin n_mode = 0; n_el = 0; end
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_el   <= 0;
      m_ccf  <= 1'b0;
      armed  <= 1'b1;
    end else if (armed && !rg_ck_fast_xstop) begin
      m_mode <= n_mode;
      m_el   <= n_el;
      m_ccf  <= cfg_ccflush_dis && (n_mode == 2 || n_mode == 3);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_state", int'(pm_state), m_mode);
      chk("m_raise", int'(ct_ck_pm_raise_tholds), int'(m_mode == 2 || m_mode == 3));
      chk("m_ack",   int'(pm_sleep_ack), int'(m_mode == 3));
      chk("m_ccf",   int'(ct_ck_pm_ccflush_disable), int'(m_ccf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; thread_pm_req = 2'b00; pm_wake = 1'b0; pm_quiesced = 1'b1;
    cfg_pm_enable = 1'b1; cfg_ccflush_dis = 1'b0; rg_ck_fast_xstop = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_state", int'(pm_state), 0);
    chk("rst_raise", int'(ct_ck_pm_raise_tholds), 0);
    chk("rst_ack",   int'(pm_sleep_ack), 0);
    chk("rst_ccf",   int'(ct_ck_pm_ccflush_disable), 0);

    // Normal sleep/wake; cycle 0 is this negedge.
    thread_pm_req = 2'b11;
    step(8);  chk("n_c8_raise", int'(ct_ck_pm_raise_tholds), 0);
              chk("n_c8_state", int'(pm_state), 1);
    step(1);  chk("n_c9_raise", int'(ct_ck_pm_raise_tholds), 1);
              chk("n_c9_state", int'(pm_state), 2);
    step(15); chk("n_c24_ack", int'(pm_sleep_ack), 0);
    step(1);  chk("n_c25_ack", int'(pm_sleep_ack), 1);
              chk("n_c25_state", int'(pm_state), 3);
    step(15); pm_wake = 1'b1;
    step(1);  chk("n_c41_raise", int'(ct_ck_pm_raise_tholds), 0);
              chk("n_c41_ack", int'(pm_sleep_ack), 0);
              chk("n_c41_state", int'(pm_state), 4);
    pm_wake = 1'b0; thread_pm_req = 2'b00;
    step(15); chk("n_c56_state", int'(pm_state), 4);
    step(1);  chk("n_c57_state", int'(pm_state), 0);
    step(3);

    // Quiesce glitch in the 5th quiesce cycle.
    thread_pm_req = 2'b11;
    for (int c = 1; c <= 13; c++) begin
      step(1);
      chk("g_state", int'(pm_state), 1);
      if (c == 5) pm_quiesced = 1'b0;
      if (c == 6) pm_quiesced = 1'b1;
    end
    step(1);  chk("g_c14_raise", int'(ct_ck_pm_raise_tholds), 1);
    thread_pm_req = 2'b00;
    step(40); chk("g_end_state", int'(pm_state), 0);

    // Partial request, then a drop during quiesce.
    thread_pm_req = 2'b01;
    step(20); chk("p_state", int'(pm_state), 0);
              chk("p_raise", int'(ct_ck_pm_raise_tholds), 0);
    thread_pm_req = 2'b11;
    step(3);  chk("p_c3_state", int'(pm_state), 1);
    thread_pm_req = 2'b01;
    step(1);  chk("p_c4_state", int'(pm_state), 0);
              chk("p_c4_raise", int'(ct_ck_pm_raise_tholds), 0);
    thread_pm_req = 2'b00;
    step(3);

    // Wake during RAISE is ignored until the thold wait completes.
    thread_pm_req = 2'b11;
    step(11); chk("a_c11_state", int'(pm_state), 2);
    pm_wake = 1'b1;
    step(14); chk("a_c25_ack", int'(pm_sleep_ack), 1);
    step(1);  chk("a_c26_ack", int'(pm_sleep_ack), 0);
              chk("a_c26_state", int'(pm_state), 4);
    pm_wake = 1'b0; thread_pm_req = 2'b00;
    step(15); chk("a_c41_state", int'(pm_state), 4);
    step(1);  chk("a_c42_state", int'(pm_state), 0);
    step(3);

    // ccflush tracking and a 10-cycle checkstop mid-RAISE, then reset in SLEEP.
    cfg_ccflush_dis = 1'b1;
    thread_pm_req = 2'b11;
    step(9);  chk("x_c9_ccf", int'(ct_ck_pm_ccflush_disable), 1);
    step(3);  rg_ck_fast_xstop = 1'b1;
    step(10); rg_ck_fast_xstop = 1'b0;
              chk("x_c22_state", int'(pm_state), 2);
    step(12); chk("x_c34_ack", int'(pm_sleep_ack), 0);
    step(1);  chk("x_c35_ack", int'(pm_sleep_ack), 1);
              chk("x_c35_ccf", int'(ct_ck_pm_ccflush_disable), 1);
    step(5);  rst = 1'b1;
    step(1);  rst = 1'b0; thread_pm_req = 2'b00;
              chk("r_raise", int'(ct_ck_pm_raise_tholds), 0);
              chk("r_ack",   int'(pm_sleep_ack), 0);
              chk("r_ccf",   int'(ct_ck_pm_ccflush_disable), 0);
              chk("r_state", int'(pm_state), 0);
    step(2);  chk("r_after_state", int'(pm_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
